// File: rtl/sisc_pkg.sv
// sisc_pkg: shared definitions for the SISC instruction-fetch slice.
// Holds the default widths and reset PC, the fetch FSM state encoding,
// and the pc_sel/br_sel encodings that ctrl also drives.
package sisc_pkg;

    localparam int          SISC_PC_W   = 16;
    localparam int          SISC_IR_W   = 32;
    localparam logic [15:0] SISC_RST_PC = 16'h0000;

    // Fetch FSM: IDLE waits for a fetch request, REQ holds the memory
    // request until the memory acknowledges it.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    // Next-PC source select.
    localparam logic PC_SEL_INC = 1'b0;
    localparam logic PC_SEL_BR  = 1'b1;

    // Branch target mode.
    localparam logic BR_SEL_REL = 1'b0;
    localparam logic BR_SEL_ABS = 1'b1;

endpackage

// File: rtl/sisc_pc.sv
// sisc_pc: program counter register, incrementer and next-PC mux.
// Ports:
//   clk, rst_f       - clock, asynchronous active-low reset
//   pc_rst           - synchronous clear to RST_PC (highest priority)
//   pc_write         - load the selected next PC this edge
//   pc_sel, br_sel   - next-PC source and branch mode
//   br_imm           - branch offset or absolute address
//   pc_out           - current PC
//   pc_inc           - pc_out + 1, wrapping
//   pc_new           - value the PC takes at the coming edge
import sisc_pkg::*;

module sisc_pc #(
    parameter int              PC_W   = SISC_PC_W,
    parameter logic [PC_W-1:0] RST_PC = PC_W'(SISC_RST_PC)
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic [PC_W-1:0] br_imm,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_inc,
    output logic [PC_W-1:0] pc_new
);

    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] next_pc;

    // All arithmetic is PC_W wide so carries out of the top bit are dropped.
    assign pc_inc    = pc_out + PC_W'(1);
    assign br_target = (br_sel == BR_SEL_ABS) ? br_imm : (pc_inc + br_imm);
    assign next_pc   = (pc_sel == PC_SEL_BR) ? br_target : pc_inc;

    // pc_new is exported so the fetch unit can latch the post-edge PC when
    // a fetch is requested on the same edge as a PC update.
    assign pc_new = pc_rst   ? RST_PC  :
                    pc_write ? next_pc :
                               pc_out;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_out <= RST_PC;
        end else begin
            pc_out <= pc_new;
        end
    end

endmodule

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: instruction-fetch stage feeding the SISC datapath.
// Ports:
//   clk, rst_f                  - clock, asynchronous active-low reset
//   pc_rst, pc_write            - PC clear / commit strobes from ctrl
//   pc_sel, br_sel, br_imm      - next-PC selection from ctrl
//   fetch_req                   - start a fetch at the current PC
//   imem_req, imem_addr         - memory request and registered address
//   imem_ack, imem_rdata        - memory acknowledge and returned word
//   ir, ir_valid                - instruction register and its valid flag
//   fetch_busy                  - a fetch is in flight
//   pc_out, pc_inc              - current PC and its increment
import sisc_pkg::*;

module sisc_ifetch #(
    parameter int              PC_W   = SISC_PC_W,
    parameter int              IR_W   = SISC_IR_W,
    parameter logic [PC_W-1:0] RST_PC = PC_W'(SISC_RST_PC)
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic [PC_W-1:0] br_imm,
    input  logic            fetch_req,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IR_W-1:0] imem_rdata,
    output logic [IR_W-1:0] ir,
    output logic            ir_valid,
    output logic            fetch_busy,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_inc
);

    fetch_state_t    state;
    fetch_state_t    next_state;
    logic [PC_W-1:0] pc_new;
    logic            discard;
    logic            flush;

    sisc_pc #(
        .PC_W   (PC_W),
        .RST_PC (RST_PC)
    ) u_pc (
        .clk      (clk),
        .rst_f    (rst_f),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .br_imm   (br_imm),
        .pc_out   (pc_out),
        .pc_inc   (pc_inc),
        .pc_new   (pc_new)
    );

    // Any PC change invalidates whatever instruction is held or in flight.
    assign flush = pc_write | pc_rst;

    // Request and busy come straight from the state register, so an
    // asynchronous reset drops them immediately.
    assign imem_req   = (state == REQ);
    assign fetch_busy = (state == REQ);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fetch_req) next_state = REQ;
            REQ:     if (imem_ack)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address, discard flag and IR. A flush during REQ cannot abort the
    // memory handshake, so it only marks the returning word for dropping;
    // a flush on the very edge of the ack drops that word as well.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            imem_addr <= '0;
            discard   <= 1'b0;
            ir        <= '0;
            ir_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        imem_addr <= pc_new;
                        ir_valid  <= 1'b0;
                        discard   <= 1'b0;
                    end else if (flush) begin
                        ir_valid  <= 1'b0;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        discard <= 1'b0;
                        if (!(discard || flush)) begin
                            ir       <= imem_rdata;
                            ir_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    discard <= 1'b0;
                end
            endcase
            if (pc_rst) begin
                ir <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sisc_ifetch.sv
// tb_sisc_ifetch: randomized and directed bench for sisc_ifetch with a
// behavioural reference model and a fetch/IR scoreboard.
module tb_sisc_ifetch;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        pc_rst = 1'b0;
    logic        pc_write = 1'b0;
    logic        pc_sel = 1'b0;
    logic        br_sel = 1'b0;
    logic [15:0] br_imm = '0;
    logic        fetch_req = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic        fetch_busy;
    logic [15:0] pc_out;
    logic [15:0] pc_inc;

    int n_checks = 0;
    int n_pass   = 0;

    sisc_ifetch dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .br_imm     (br_imm),
        .fetch_req  (fetch_req),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .pc_out     (pc_out),
        .pc_inc     (pc_inc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: the PC as a plain integer, a "fetch outstanding"
    // flag, the address of that fetch and whether it has been flushed.
    logic [15:0] m_pc = RST_PC;
    logic [31:0] m_ir = '0;
    logic        m_irv = 1'b0;
    logic        m_busy = 1'b0;
    logic [15:0] m_addr = '0;
    logic        m_flushed = 1'b0;
    logic [15:0] addr_q[$];
    logic [31:0] ir_q[$];

    function automatic logic [15:0] refNextPc(input int pc, input bit rst, input bit wr,
                                              input bit sel, input bit bsel, input int imm);
        if (rst)  return RST_PC;
        if (!wr)  return 16'(pc);
        if (!sel) return 16'((pc + 1) % 65536);
        if (bsel) return 16'(imm);
        return 16'((pc + 1 + imm) % 65536);
    endfunction

    always @(posedge clk or negedge rst_f) begin
        logic [15:0] npc;
        bit          chg;
        if (!rst_f) begin
            m_pc = RST_PC; m_ir = '0; m_irv = 1'b0; m_busy = 1'b0;
            m_addr = '0; m_flushed = 1'b0;
            addr_q.delete(); ir_q.delete();
        end else begin
            chg = pc_rst || pc_write;
            npc = refNextPc(int'(m_pc), pc_rst, pc_write, pc_sel, br_sel, int'(br_imm));
            if (!m_busy) begin
                if (chg) m_irv = 1'b0;
                if (fetch_req) begin
                    m_busy = 1'b1; m_addr = npc; m_irv = 1'b0; m_flushed = 1'b0;
                    addr_q.push_back(npc);
                end
            end else if (imem_ack) begin
                m_busy = 1'b0;
                if (!(m_flushed || chg)) begin
                    m_ir = imem_rdata; m_irv = 1'b1;
                    ir_q.push_back(imem_rdata);
                end
                m_flushed = 1'b0;
            end else if (chg) begin
                m_flushed = 1'b1;
            end
            if (pc_rst) m_ir = '0;
            m_pc = npc;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT starts a request or
    // presents a new instruction, and tracks the model every cycle.
    logic prev_req = 1'b0;
    logic prev_irv = 1'b0;

    always @(negedge clk) begin
        if (rst_f) begin
            if (imem_req && !prev_req) begin
                if (addr_q.size() == 0) checkOutput("sb_addr_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
                else                    checkOutput("sb_fetch_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
            end
            if (ir_valid && !prev_irv) begin
                if (ir_q.size() == 0) checkOutput("sb_ir_unexpected", ir, 32'hFFFF_FFFF);
                else                  checkOutput("sb_ir", ir, ir_q.pop_front());
            end
            checkOutput("m_pc_out", 32'(pc_out), 32'(m_pc));
            checkOutput("m_pc_inc", 32'(pc_inc), 32'(16'(m_pc + 16'd1)));
            checkOutput("m_busy", 32'(fetch_busy), 32'(m_busy));
            checkOutput("m_imem_req", 32'(imem_req), 32'(m_busy));
            checkOutput("m_ir_valid", 32'(ir_valid), 32'(m_irv));
            checkOutput("m_ir", ir, m_ir);
            if (m_busy) checkOutput("m_imem_addr", 32'(imem_addr), 32'(m_addr));
        end
        prev_req = imem_req;
        prev_irv = ir_valid;
    end

    task automatic applyStimulus(input bit freq, input bit wr, input bit sel, input bit bsel,
                                 input logic [15:0] imm, input bit prst, input bit ack,
                                 input logic [31:0] rdata);
        fetch_req = freq; pc_write = wr; pc_sel = sel; br_sel = bsel;
        br_imm = imm; pc_rst = prst; imem_ack = ack; imem_rdata = rdata;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    int wait_cnt = 0;

    initial begin
        $display("[TB] sisc_ifetch bench start");
        repeat (2) @(negedge clk);
        checkOutput("rst_pc", 32'(pc_out), 32'(RST_PC));
        checkOutput("rst_ir", ir, 32'h0);
        checkOutput("rst_ir_valid", 32'(ir_valid), 32'h0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'h0);
        checkOutput("rst_busy", 32'(fetch_busy), 32'h0);
        rst_f = 1'b1;

        // Zero-wait fetch.
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 32'h0); cycle();
        checkOutput("f0_req", 32'(imem_req), 32'h1);
        checkOutput("f0_addr", 32'(imem_addr), 32'h0);
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1, 32'h1234_5678); cycle();
        checkOutput("f0_ir", ir, 32'h1234_5678);
        checkOutput("f0_ir_valid", 32'(ir_valid), 32'h1);
        checkOutput("f0_pc", 32'(pc_out), 32'h0);

        // Three wait cycles with an ignored fetch_req pulse in the middle.
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 32'h0); cycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("wait_req", 32'(imem_req), 32'h1);
            checkOutput("wait_addr", 32'(imem_addr), 32'h0);
            checkOutput("wait_busy", 32'(fetch_busy), 32'h1);
            if (i == 2) applyStimulus(0, 0, 0, 0, 16'h0, 0, 1, 32'hCAFE_F00D);
            else        applyStimulus(i == 0, 0, 0, 0, 16'h0, 0, 0, 32'h0);
            cycle();
        end
        checkOutput("wait_ir", ir, 32'hCAFE_F00D);
        checkOutput("wait_ir_valid", 32'(ir_valid), 32'h1);
        checkOutput("wait_pulse_ignored", 32'(imem_req), 32'h0);

        // Branch arithmetic and wrap-around.
        applyStimulus(0, 1, 1, 1, 16'hFFFF, 0, 0, 32'h0); cycle();
        checkOutput("br_abs_ffff", 32'(pc_out), 32'hFFFF);
        checkOutput("br_idle_flush", 32'(ir_valid), 32'h0);
        applyStimulus(0, 1, 0, 0, 16'h0, 0, 0, 32'h0); cycle();
        checkOutput("br_inc_wrap", 32'(pc_out), 32'h0);
        applyStimulus(0, 1, 1, 1, 16'h00F0, 0, 0, 32'h0); cycle();
        applyStimulus(0, 1, 1, 0, 16'hFF00, 0, 0, 32'h0); cycle();
        checkOutput("br_rel", 32'(pc_out), 32'hFFF1);
        applyStimulus(0, 1, 1, 1, 16'h0040, 0, 0, 32'h0); cycle();
        checkOutput("br_abs_0040", 32'(pc_out), 32'h0040);

        // Branch during REQ: the returning word is dropped.
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 32'h0); cycle();
        checkOutput("fl_addr", 32'(imem_addr), 32'h0040);
        applyStimulus(0, 1, 1, 1, 16'h0080, 0, 0, 32'h0); cycle();
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 32'h0); cycle();
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1, 32'hDEAD_BEEF); cycle();
        checkOutput("fl_ir_kept", ir, 32'hCAFE_F00D);
        checkOutput("fl_ir_valid", 32'(ir_valid), 32'h0);
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 32'h0); cycle();
        checkOutput("fl_next_addr", 32'(imem_addr), 32'h0080);
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1, 32'h1111_2222); cycle();
        checkOutput("fl_next_ir", ir, 32'h1111_2222);

        // pc_write and fetch_req on the same edge fetch from the new PC.
        applyStimulus(0, 1, 1, 1, 16'h0005, 0, 0, 32'h0); cycle();
        applyStimulus(1, 1, 0, 0, 16'h0, 0, 0, 32'h0); cycle();
        checkOutput("same_edge_addr", 32'(imem_addr), 32'h0006);
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1, 32'h3333_4444); cycle();

        // Asynchronous reset in the middle of a request.
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 32'h0); cycle();
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 32'h0);
        @(posedge clk); #2 rst_f = 1'b0; #1;
        checkOutput("ar_req", 32'(imem_req), 32'h0);
        checkOutput("ar_busy", 32'(fetch_busy), 32'h0);
        checkOutput("ar_ir_valid", 32'(ir_valid), 32'h0);
        checkOutput("ar_pc", 32'(pc_out), 32'(RST_PC));
        @(negedge clk); rst_f = 1'b1;
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 32'h0); cycle();
        checkOutput("ar_refetch_addr", 32'(imem_addr), 32'(RST_PC));
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1, 32'h5555_6666); cycle();

        // Randomized traffic, checked by the model and scoreboard.
        for (int i = 0; i < 600; i++) begin
            bit ack;
            wait_cnt = imem_req ? wait_cnt + 1 : 0;
            ack = imem_req ? (wait_cnt >= 4 || $urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          16'($urandom), $urandom_range(0, 15) == 0, ack, $urandom);
            cycle();
        end

        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1, 32'h0);
        repeat (3) cycle();
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 32'h0);
        cycle();
        checkOutput("sb_addr_drained", 32'(addr_q.size()), 32'h0);
        checkOutput("sb_ir_drained", 32'(ir_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sisc_ifetch.md
Name: sisc_ifetch

Overview:
Instruction-fetch stage that sits directly upstream of the SISC datapath/control top level and produces the 32-bit `ir` that top level consumes.
- Owns the 16-bit program counter, incrementer and branch-target mux.
- Drives a request/acknowledge instruction-memory port with variable latency and latches the returned word into the instruction register.
- Is driven by the `pc_rst`, `pc_write`, `pc_sel` and `br_sel` strobes from `ctrl`, plus a fetch request.

Parameters:
- PC_W, 16, program counter and instruction-memory address width
- IR_W, 32, instruction word width
- RST_PC, 16'h0000, PC value after reset or `pc_rst`

Ports:
- clk  in  1  system clock, rising edge
- rst_f  in  1  asynchronous, active-low reset
- pc_rst  in  1  synchronous PC clear/abort from ctrl
- pc_write  in  1  commit next PC this edge
- pc_sel  in  1  0 = next PC is pc_inc, 1 = next PC is branch target
- br_sel  in  1  0 = relative target (pc_inc + br_imm), 1 = absolute target (br_imm)
- br_imm  in  PC_W  branch offset/address (instruction bits [15:0])
- fetch_req  in  1  ctrl requests a fetch at the current PC
- imem_req  out  1  memory request, held until ack
- imem_addr  out  PC_W  registered fetch address
- imem_ack  in  1  memory data valid; sampled only while imem_req=1
- imem_rdata  in  IR_W  instruction word, valid with imem_ack
- ir  out  IR_W  instruction register
- ir_valid  out  1  ir holds a fetched, non-flushed instruction
- fetch_busy  out  1  fetch in flight; fetch_req is ignored while high
- pc_out  out  PC_W  current PC
- pc_inc  out  PC_W  pc_out+1 mod 2^PC_W (combinational)

Behaviour:
- Reset (rst_f=0, async):
  - pc_out=RST_PC, ir=0, ir_valid=0.
  - imem_req=0, imem_addr=0, fetch_busy=0, state=IDLE, discard=0.
- Next-PC:
  - pc_sel=0 gives pc_inc.
  - pc_sel=1, br_sel=1 gives br_imm.
  - pc_sel=1, br_sel=0 gives pc_inc+br_imm.
  - All sums wrap modulo 2^PC_W, with no overflow flag.
- PC update priority per edge:
  - pc_rst: PC=RST_PC.
  - else pc_write: PC=next-PC.
  - else PC holds.
- FSM states: IDLE, REQ.
  - IDLE -> REQ on fetch_req=1.
    - imem_addr latches the PC value that is valid after this edge. If pc_write or pc_rst is active on the same edge, the fetch uses the new PC.
    - imem_req=1 and fetch_busy=1 from the next cycle.
    - ir_valid clears on this edge.
  - REQ holds imem_req and imem_addr stable until imem_ack=1.
  - REQ -> IDLE on imem_ack=1.
    - If discard=0: ir<=imem_rdata, ir_valid<=1.
    - If discard=1: data is dropped, ir_valid stays 0, discard clears.
- Minimum latency: fetch_req at edge N gives ir_valid=1 after edge N+1, when the ack arrives in the first REQ cycle. Each wait cycle adds 1.
- Flush:
  - pc_write or pc_rst while in REQ sets discard=1.
  - The memory handshake is never dropped mid-request: REQ waits for the ack, then discards the data.
- pc_write or pc_rst in IDLE clears ir_valid.
- pc_rst additionally sets ir=0.
- fetch_req while fetch_busy=1 has no effect; it is not queued.
- imem_ack while imem_req=0 is ignored.
- Async reset mid-fetch returns to the reset state immediately. The memory observes imem_req falling, which is permitted only on reset.

Decomposition:
- Shared package sisc_pkg holds:
  - PC_W, IR_W, RST_PC defaults
  - the FSM state encoding (IDLE=1'b0, REQ=1'b1)
  - the br_sel/pc_sel encoding constants, shared with ctrl
- One sub-module, sisc_pc, holds the PC register, incrementer and next-PC mux (pc_rst/pc_write priority).
- sisc_ifetch instantiates sisc_pc and contains the fetch FSM, imem_addr register, discard flag and IR register.

Test Plan:
- Reset then fetch_req with imem_ack in the first REQ cycle, rdata=32'h1234_5678 -> pc_out=0, imem_addr=0, ir=32'h1234_5678, ir_valid=1 two edges after fetch_req.
- 3-cycle memory wait -> imem_req and imem_addr=0 stable for 3 cycles, fetch_busy=1 throughout; a fetch_req pulse during the wait is ignored; ir_valid rises 1 edge after the ack.
- Branch arithmetic:
  - PC=16'hFFFF, pc_write with pc_sel=0 -> PC=0.
  - PC=16'h00F0, pc_sel=1, br_sel=0, br_imm=16'hFF00 -> PC=16'hFFF1.
  - pc_sel=1, br_sel=1, br_imm=16'h0040 -> PC=16'h0040.
- pc_write with pc_sel=1, br_sel=1, br_imm=16'h0080 during REQ, ack 2 cycles later with rdata=32'hDEAD_BEEF -> ir unchanged, ir_valid=0; the next fetch_req yields imem_addr=16'h0080.
- pc_write (PC 5->6) and fetch_req on the same edge -> imem_addr=6.
- rst_f asserted mid-REQ (asynchronously, between edges) -> imem_req, ir_valid and fetch_busy go to 0 and pc_out=RST_PC without waiting for a clock edge; after release, a fresh fetch starts at RST_PC.
